// File: rtl/bullet_ctrl.sv
// bullet_ctrl: fixed pool of NUM_BULLETS bullets for one tank. It spawns on shoot edges, moves live bullets once per frame and retires them.
// Define BULLET_BOUNCE_EN to make wall hits reflect the velocity instead of retiring the bullet.
module bullet_ctrl #(
  parameter int         NUM_BULLETS  = 4,
  parameter int         BULLET_SPEED = 8,
  parameter logic [9:0] LIFETIME     = 10'd300,
  parameter logic [5:0] COOLDOWN     = 6'd15,
  parameter logic [9:0] SCREEN_X_MAX = 10'd639,
  parameter logic [9:0] SCREEN_Y_MAX = 10'd479
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic [1:0]                game_end,
  input  logic                      ShootBullet,
  input  logic [9:0]                TankX,
  input  logic [9:0]                TankY,
  input  logic [7:0]                sin,
  input  logic [7:0]                cos,
  input  logic [NUM_BULLETS-1:0]    wall_hit_x,
  input  logic [NUM_BULLETS-1:0]    wall_hit_y,
  input  logic [NUM_BULLETS-1:0]    bullet_kill,
  output logic [10*NUM_BULLETS-1:0] BulletX,
  output logic [10*NUM_BULLETS-1:0] BulletY,
  output logic [NUM_BULLETS-1:0]    BulletActive,
  output logic                      ShotFired
);

`ifdef BULLET_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  localparam logic [6:0] SPEED7 = 7'(BULLET_SPEED);

  // Sign-magnitude direction to signed per-frame step; invert flips the forward sense.
  function automatic logic signed [9:0] dir_step(input logic [7:0] sm, input logic invert);
    logic [12:0]       prod;
    logic signed [9:0] mag;
    prod = 13'({7'd0, SPEED7} * {7'd0, sm[6:0]});
    mag  = $signed(10'(prod >> 7));
    return (sm[7] ^ invert) ? -mag : mag;
  endfunction

  logic [9:0]              pos_x   [NUM_BULLETS];
  logic [9:0]              pos_y   [NUM_BULLETS];
  logic signed [9:0]       vel_x   [NUM_BULLETS];
  logic signed [9:0]       vel_y   [NUM_BULLETS];
  logic [9:0]              life    [NUM_BULLETS];
  logic [NUM_BULLETS-1:0]  active;
  logic [5:0]              cool;
  logic                    shoot_q;

  logic [9:0]              nx_x    [NUM_BULLETS];
  logic [9:0]              nx_y    [NUM_BULLETS];
  logic signed [9:0]       nx_vx   [NUM_BULLETS];
  logic signed [9:0]       nx_vy   [NUM_BULLETS];
  logic [9:0]              nx_life [NUM_BULLETS];
  logic [NUM_BULLETS-1:0]  nx_act;
  logic [5:0]              nx_cool;
  logic                    nx_fire;

  logic signed [9:0]       eff_vx  [NUM_BULLETS];
  logic signed [9:0]       eff_vy  [NUM_BULLETS];
  logic [9:0]              mv_x    [NUM_BULLETS];
  logic [9:0]              mv_y    [NUM_BULLETS];
  logic signed [9:0]       spawn_vx;
  logic signed [9:0]       spawn_vy;
  logic [NUM_BULLETS-1:0]  spawn_sel;
  logic                    spawn_ok;
  logic                    taken;

  always_comb begin
    spawn_ok  = ShootBullet & ~shoot_q & (cool == 6'd0);
    spawn_vx  = dir_step(cos, 1'b0);
    spawn_vy  = dir_step(sin, 1'b1);
    taken     = 1'b0;
    spawn_sel = '0;
    // Lowest free slot wins; slots freed this edge are not visible until the next.
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (spawn_ok && !active[i] && !taken) begin
        spawn_sel[i] = 1'b1;
        taken        = 1'b1;
      end
    end
    nx_fire = taken;
    nx_cool = taken ? COOLDOWN : ((cool != 6'd0) ? cool - 6'd1 : 6'd0);

    for (int i = 0; i < NUM_BULLETS; i++) begin
      nx_x[i]    = pos_x[i];
      nx_y[i]    = pos_y[i];
      nx_vx[i]   = vel_x[i];
      nx_vy[i]   = vel_y[i];
      nx_life[i] = life[i];
      nx_act[i]  = active[i];
      eff_vx[i]  = (BOUNCE && wall_hit_x[i]) ? -vel_x[i] : vel_x[i];
      eff_vy[i]  = (BOUNCE && wall_hit_y[i]) ? -vel_y[i] : vel_y[i];
      mv_x[i]    = pos_x[i] + $unsigned(eff_vx[i]);
      mv_y[i]    = pos_y[i] + $unsigned(eff_vy[i]);
      if (spawn_sel[i]) begin
        nx_x[i]    = TankX;
        nx_y[i]    = TankY;
        nx_vx[i]   = spawn_vx;
        nx_vy[i]   = spawn_vy;
        nx_life[i] = LIFETIME;
        nx_act[i]  = 1'b1;
      end else if (active[i]) begin
        if (bullet_kill[i]) begin
          nx_act[i] = 1'b0;
        end else if (life[i] == 10'd1) begin
          nx_act[i] = 1'b0;
        end else if (!BOUNCE && (wall_hit_x[i] || wall_hit_y[i])) begin
          nx_act[i] = 1'b0;
        end else begin
          // Negative wrap lands above the screen limits, so one compare covers both edges.
          nx_x[i]    = mv_x[i];
          nx_y[i]    = mv_y[i];
          nx_vx[i]   = eff_vx[i];
          nx_vy[i]   = eff_vy[i];
          nx_life[i] = life[i] - 10'd1;
          nx_act[i]  = (mv_x[i] <= SCREEN_X_MAX) && (mv_y[i] <= SCREEN_Y_MAX);
        end
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      shoot_q   <= 1'b0;
      active    <= '0;
      cool      <= 6'd0;
      ShotFired <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        vel_x[i] <= '0;
        vel_y[i] <= '0;
        life[i]  <= '0;
      end
    end else begin
      shoot_q <= ShootBullet;
      if (game_end != 2'b00) begin
        active    <= '0;
        cool      <= 6'd0;
        ShotFired <= 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
          pos_x[i] <= '0;
          pos_y[i] <= '0;
          vel_x[i] <= '0;
          vel_y[i] <= '0;
          life[i]  <= '0;
        end
      end else begin
        active    <= nx_act;
        cool      <= nx_cool;
        ShotFired <= nx_fire;
        for (int i = 0; i < NUM_BULLETS; i++) begin
          pos_x[i] <= nx_x[i];
          pos_y[i] <= nx_y[i];
          vel_x[i] <= nx_vx[i];
          vel_y[i] <= nx_vy[i];
          life[i]  <= nx_life[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_out
    assign BulletX[10*g +: 10] = pos_x[g];
    assign BulletY[10*g +: 10] = pos_y[g];
  end
  assign BulletActive = active;

endmodule

// File: doc/bullet_ctrl.md
Name: bullet_ctrl

Overview:
- Downstream consumer of the tank controller's ShootBullet, TankX/TankY and Angle-derived sin/cos outputs.
- Manages a fixed pool of bullets for one tank. It spawns a bullet on each new shoot request, moves every live bullet once per frame along its firing direction, and retires bullets on expiry, wall hit, tank hit, screen exit or game end.
- Feeds the bullet positions to the collision and sprite-draw logic.

Parameters:
NUM_BULLETS, 4, pool size (1..8)
BULLET_SPEED, 8, speed scale; step = (BULLET_SPEED*mag)>>7
LIFETIME, 10'd300, frames a bullet lives
COOLDOWN, 6'd15, frames after a spawn before the next spawn is allowed
SCREEN_X_MAX, 10'd639, rightmost legal X
SCREEN_Y_MAX, 10'd479, bottommost legal Y

Ports:
frame_clk  in  1  frame clock; all state updates on its rising edge
Reset  in  1  asynchronous, active-low reset
game_end  in  2  nonzero = clear the pool
ShootBullet  in  1  shoot request level from the tank
TankX  in  10  tank X at the time of the shot
TankY  in  10  tank Y at the time of the shot
sin  in  8  sign-magnitude; bit7 = sign, [6:0] = magnitude/128
cos  in  8  same format as sin
wall_hit_x  in  NUM_BULLETS  per slot: bullet touching a vertical wall
wall_hit_y  in  NUM_BULLETS  per slot: bullet touching a horizontal wall
bullet_kill  in  NUM_BULLETS  per slot: bullet hit a tank
BulletX  out  10*NUM_BULLETS  packed; slot i at [10i+9:10i]
BulletY  out  10*NUM_BULLETS  packed, same layout
BulletActive  out  NUM_BULLETS  slot live
ShotFired  out  1  one-frame pulse on a successful spawn

Behaviour:
- Reset low: all BulletActive=0, BulletX/BulletY=0, velocities=0, life counters=0, cooldown=0, ShotFired=0, shoot edge register=0.
- Priority per edge: Reset > game_end!=0 > normal operation.
  - game_end!=0 behaves like reset on every edge it is held, except the shoot edge register keeps tracking ShootBullet. A held ShootBullet therefore does not fire after game_end clears.
- Shoot request = ShootBullet & ~shoot_q, where shoot_q is ShootBullet registered. A held key gives exactly one request.
- Spawn conditions (all required): request, cooldown==0, at least one free slot in the BulletActive value at the start of the edge.
  - Chosen slot = lowest free index.
  - Slot loads X=TankX, Y=TankY, life=LIFETIME, Active=1.
  - Velocity is latched at spawn and held constant: vx=+cos step, vy=-sin step. Forward is +cos on X and -sin on Y, matching tank forward motion.
  - Cooldown loads COOLDOWN; ShotFired=1 for that edge only.
  - The spawned bullet does not move on its spawn edge.
- If a spawn condition fails, the request is dropped (not queued) and ShotFired=0.
- Step arithmetic: step magnitude = product[12:7] of BULLET_SPEED[6:0]*mag[6:0]. Sign-extend to 10-bit two's complement; a set sign bit negates the step. Magnitude 0 gives step 0 regardless of sign.
- Cooldown decrements by 1 per edge while nonzero and saturates at 0.
- Each live slot not spawned this edge, in priority order:
  1. bullet_kill[i] → Active=0.
  2. life==1 → Active=0 (expiry).
  3. Otherwise apply wall response (see Optional Feature), then X+=vx, Y+=vy (10-bit wrap), life-=1.
  4. After the move, X>SCREEN_X_MAX or Y>SCREEN_Y_MAX (including negative wrap to 10'h3xx) → Active=0.
- Inactive slots hold their last X/Y and ignore wall_hit and bullet_kill.
- A slot freed on an edge is not reusable until the next edge.
- wall_hit_x and wall_hit_y both set on the same slot: both velocity components respond on that edge.

Optional Feature:
BULLET_BOUNCE_EN.
- Defined: wall_hit_x[i] negates vx and wall_hit_y[i] negates vy before the move. The bullet stays live.
- Undefined: any wall_hit on a live slot sets Active=0 with no move. Kill/expiry priority is unchanged.

Test Plan:
- Reset low, then high, then ShootBullet=1 with TankX=100, TankY=200, cos=8'h7F, sin=0, hold for 3 edges → slot0 active at (100,200) after edge 1 with ShotFired=1; (107,200) after edge 2; (114,200) after edge 3. Exactly one bullet.
- Press/release 5 times, 20 frames apart, no bullets killed → slots 0-3 fill in order; 5th press dropped (ShotFired=0). Press within 15 frames of a spawn → dropped.
- Spawn with sin=8'h7F, cos=0 at Y=5 → Y=5-7 wraps to 10'h3FE → slot inactive on that edge.
- vx=+7; pulse wall_hit_x[0] at X=300 → with BULLET_BOUNCE_EN, next X=293 and slot stays live; without it, slot inactive and X held at 300.
- Live slot with life=1 and bullet_kill=1 on the same edge → inactive. Let another slot run 300 frames untouched → inactive on frame 300.
- game_end=2'b01 for one edge with 3 live bullets → BulletActive=0, positions=0. With ShootBullet held across that edge → no spawn afterwards until it is released and pressed again.
